// File: rtl/sc_pkg.sv
// Shared types and default sizing for the stochastic stream counter.
// The FSM state encoding lives here so the bench and checkers can decode it.
package sc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } sc_state_e;

    localparam int SC_N  = 12;
    localparam int SC_CH = 4;

endpackage

// File: rtl/sc_ch_acc.sv
// Per-channel ones-counter for one stochastic bit stream.
// The result includes the bit present this cycle, so the owner can capture it at the final window edge.
module sc_ch_acc
    import sc_pkg::*;
#(
    parameter int N = SC_N
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [N:0] result
);

    logic [N:0] acc;

    // Clear wins over enable so a back-to-back window starts from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{N{1'b0}}, bit_in};
        end
    end

    assign result = acc + {{N{1'b0}}, bit_in};

endmodule

// File: rtl/sc_stream_counter.sv
// Counts ones on CH stochastic streams over 2^N-cycle windows and publishes the decoded values.
// Handshake: valid pulses for one cycle on the edge out changes; out then holds until the next pulse.
module sc_stream_counter
    import sc_pkg::*;
#(
    parameter int N       = SC_N,
    parameter int CH      = SC_CH,
    parameter int BIPOLAR = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cont,
    input  logic [CH-1:0]         bits_in,
    output logic [CH*(N+1)-1:0]   out,
    output logic                  valid,
    output logic                  busy
);

    localparam logic [N:0] BIAS = (BIPOLAR != 0) ? ((N+1)'(1) << (N-1)) : '0;

    sc_state_e            state;
    sc_state_e            state_nxt;
    logic [N-1:0]         cyc;
    logic                 win_end;
    logic                 acc_clr;
    logic                 acc_en;
    logic [CH*(N+1)-1:0]  res_flat;
    logic [CH*(N+1)-1:0]  out_nxt;

    assign win_end = (state == COUNT) && (cyc == '1);
    assign acc_en  = (state == COUNT);
    assign acc_clr = win_end || ((state == IDLE) && start);
    assign busy    = (state == COUNT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COUNT;
            COUNT:   if (win_end && !cont) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // One shared cycle counter; its wrap marks the last edge of every window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc <= '0;
        end else if (state == COUNT) begin
            cyc <= cyc + N'(1);
        end else begin
            cyc <= '0;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        sc_ch_acc #(.N(N)) u_acc (
            .clock   (clock),
            .reset_n (reset_n),
            .clr     (acc_clr),
            .en      (acc_en),
            .bit_in  (bits_in[c]),
            .result  (res_flat[c*(N+1) +: N+1])
        );
    end

    // Bipolar decode is an offset removal on the way into the output register.
    always_comb begin
        out_nxt = '0;
        for (int c = 0; c < CH; c++) begin
            out_nxt[c*(N+1) +: N+1] = res_flat[c*(N+1) +: N+1] - BIAS;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            valid <= win_end;
            if (win_end) begin
                out <= out_nxt;
            end
        end
    end

endmodule
